// File: rtl/fixedpointscaler_mc_pkg.sv
// Shared widths and the round/shift/saturate helper for the
// multi-lane output scaler.
package fxp_scaler_pkg;

  localparam int DEF_BA = 27;
  localparam int DEF_BB = 16;
  localparam int DEF_BP = 48;

  localparam int PRE_W  = DEF_BA + 1;
  localparam int PROD_W = DEF_BA + DEF_BB + 1;
  localparam int RND_W  = DEF_BP + 1;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } rss_t;

  // Works at 65 bits so the round-add never wraps for bp <= 63.
  function automatic rss_t round_shift_sat(
    input logic signed [63:0] v,
    input int                 sh,
    input int                 bp,
    input int                 bo
  );
    logic signed [64:0] x;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    int                 s;
    rss_t               r;
    s  = (sh > bp - 1) ? bp - 1 : sh;
    x  = {v[63], v};
    if (s > 0)
      x = x + (65'sd1 <<< (s - 1));
    x  = x >>> s;
    hi = (65'sd1 <<< (bo - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (bo - 1));
    r.sat = (x > hi) || (x < lo);
    if (x > hi)
      r.val = hi[63:0];
    else if (x < lo)
      r.val = lo[63:0];
    else
      r.val = x[63:0];
    return r;
  endfunction

endpackage

// File: rtl/fixedpointscaler_mc_if.sv
// Beat handshake bundle for the multi-lane scaler.
// master drives beats in; slave is the scaler.
interface fixedpointscaler_mc_if #(
  parameter int NCH = 4,
  parameter int BA  = 27,
  parameter int BB  = 16,
  parameter int BC  = 27,
  parameter int BD  = 27,
  parameter int BO  = 16,
  parameter int BS  = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [NCH*BA-1:0] in_a;
  logic [NCH*BB-1:0] in_b;
  logic [NCH*BC-1:0] in_c;
  logic [NCH*BD-1:0] in_d;
  logic [BS-1:0]     cfg_shift;
  logic              cfg_preadd_en;
  logic              out_valid;
  logic              out_ready;
  logic [NCH*BO-1:0] out_p;
  logic [NCH-1:0]    out_sat;
  logic [15:0]       sat_cnt;

  modport master (
    output in_valid, in_a, in_b, in_c, in_d,
    output cfg_shift, cfg_preadd_en, out_ready,
    input  in_ready, out_valid, out_p,
    input  out_sat, sat_cnt
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_d,
    input  cfg_shift, cfg_preadd_en, out_ready,
    output in_ready, out_valid, out_p,
    output out_sat, sat_cnt
  );
endinterface

// File: rtl/fixedpointscaler_mc_lane.sv
// One scaler lane: S1 operands, S2 preadd, S3 multiply,
// S4 post-add, S5 round/shift/saturate.
module fixedpointscaler_lane
  import fxp_scaler_pkg::*;
#(
  parameter int BA = 27,
  parameter int BB = 16,
  parameter int BC = 27,
  parameter int BD = 27,
  parameter int BP = 48,
  parameter int BO = 16,
  parameter int BS = 6
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 ld,
  input  logic                 pre_en,
  input  logic        [BS-1:0] shift,
  input  logic signed [BA-1:0] a,
  input  logic signed [BB-1:0] b,
  input  logic signed [BC-1:0] c,
  input  logic signed [BD-1:0] d,
  output logic signed [BO-1:0] p,
  output logic                 sat
);

  localparam int PW  = ((BA > BD) ? BA : BD) + 1;
  localparam int PRW = PW + BB;

  logic signed [BA-1:0]  a1;
  logic signed [BD-1:0]  d1;
  logic signed [BB-1:0]  b1, b2;
  logic signed [BC-1:0]  c1, c2, c3;
  logic signed [PW-1:0]  pre;
  logic signed [PRW-1:0] m;
  logic signed [BP-1:0]  acc;

  // No reset on the DSP-mapped registers; valids qualify them.
  always_ff @(posedge clk) begin
    if (en) begin
      a1  <= a;
      b1  <= b;
      c1  <= c;
      d1  <= pre_en ? d : '0;
      pre <= PW'(a1) + PW'(d1);
      b2  <= b1;
      c2  <= c1;
      m   <= PRW'(pre) * PRW'(b2);
      c3  <= c2;
      acc <= BP'(m) + BP'(c3);
    end
  end

  rss_t r;
  logic unused_hi;

  always_comb begin
    r = round_shift_sat({{(64-BP){acc[BP-1]}}, acc},
                        int'(shift), BP, BO);
  end

  assign unused_hi = ^r.val[63:BO];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      p   <= '0;
      sat <= 1'b0;
    end else if (ld) begin
      p   <= r.val[BO-1:0];
      sat <= r.sat;
    end
  end

endmodule

// File: rtl/fixedpointscaler_mc.sv
// Multi-lane output scaler: NCH lanes behind one
// valid/ready handshake with shared shift and preadd enable.
module fixedpointscaler_mc
  import fxp_scaler_pkg::*;
#(
  parameter int NCH = 4,
  parameter int BA  = 27,
  parameter int BB  = 16,
  parameter int BC  = 27,
  parameter int BD  = 27,
  parameter int BP  = 48,
  parameter int BO  = 16,
  parameter int BS  = 6
) (
  input logic                 clk,
  input logic                 clr,
  fixedpointscaler_mc_if.slave bus
);

  if (BP < BA + BB + 2) begin : g_bp_chk
    $error("fixedpointscaler_mc: BP < BA+BB+2");
  end

  logic          en;
  logic [4:0]    v;
  logic [BS-1:0] sh [4];
  logic [15:0]   cnt;

  // Whole pipe stalls together; bubbles keep their slot.
  assign en            = bus.out_ready | ~v[4];
  assign bus.in_ready  = en;
  assign bus.out_valid = v[4];
  assign bus.sat_cnt   = cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      v <= '0;
    else if (en)
      v <= {v[3:0], bus.in_valid};
  end

  always_ff @(posedge clk) begin
    if (en) begin
      sh[0] <= bus.cfg_shift;
      for (int k = 1; k < 4; k++)
        sh[k] <= sh[k-1];
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      cnt <= '0;
    else if (v[4] & bus.out_ready &
             (|bus.out_sat) & ~(&cnt))
      cnt <= cnt + 16'd1;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    fixedpointscaler_lane #(
      .BA(BA), .BB(BB), .BC(BC), .BD(BD),
      .BP(BP), .BO(BO), .BS(BS)
    ) u_lane (
      .clk    (clk),
      .clr    (clr),
      .en     (en),
      .ld     (en & v[3]),
      .pre_en (bus.cfg_preadd_en),
      .shift  (sh[3]),
      .a      (bus.in_a[i*BA +: BA]),
      .b      (bus.in_b[i*BB +: BB]),
      .c      (bus.in_c[i*BC +: BC]),
      .d      (bus.in_d[i*BD +: BD]),
      .p      (bus.out_p[i*BO +: BO]),
      .sat    (bus.out_sat[i])
    );
  end

endmodule

// File: tb/tb_fixedpointscaler_mc.sv
// Directed table plus stall, reset and random streams
// for the multi-lane scaler.
module tb_fixedpointscaler_mc;

  localparam int NCH = 4;
  localparam int BA  = 27;
  localparam int BB  = 16;
  localparam int BC  = 27;
  localparam int BD  = 27;
  localparam int BP  = 48;
  localparam int BO  = 16;
  localparam int BS  = 6;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  fixedpointscaler_mc_if #(
    .NCH(NCH), .BA(BA), .BB(BB), .BC(BC),
    .BD(BD), .BO(BO), .BS(BS)
  ) bus ();

  fixedpointscaler_mc #(
    .NCH(NCH), .BA(BA), .BB(BB), .BC(BC),
    .BD(BD), .BP(BP), .BO(BO), .BS(BS)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  longint la [NCH];
  longint lb [NCH];
  longint lc [NCH];
  longint ldd[NCH];
  int     lsh;
  bit     lpe;

  logic [NCH*BO-1:0] ep;
  logic [NCH-1:0]    es;
  int                exp_cnt = 0;

  typedef struct {
    logic [NCH*BO-1:0] p;
    logic [NCH-1:0]    s;
  } beat_t;
  beat_t q[$];

  typedef struct {
    longint a, b, c, d;
    int     sh;
    bit     pe;
    longint exp;
    bit     esat;
  } vec_t;
  vec_t tv[10];

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic longint mdl(
    input longint a, b, c, d,
    input int sh, input bit pe,
    output bit sat
  );
    longint p, hi, lo;
    int s;
    p  = (pe ? a + d : a) * b + c;
    s  = (sh > BP - 1) ? BP - 1 : sh;
    if (s > 0)
      p = (p + (longint'(1) << (s - 1))) >>> s;
    hi = (longint'(1) << (BO - 1)) - 1;
    lo = -hi - 1;
    sat = (p > hi) || (p < lo);
    return (p > hi) ? hi : ((p < lo) ? lo : p);
  endfunction

  task automatic apply_ops();
    bit     s;
    longint r;
    for (int i = 0; i < NCH; i++) begin
      bus.in_a[i*BA +: BA] = la[i][BA-1:0];
      bus.in_b[i*BB +: BB] = lb[i][BB-1:0];
      bus.in_c[i*BC +: BC] = lc[i][BC-1:0];
      bus.in_d[i*BD +: BD] = ldd[i][BD-1:0];
      r = mdl(la[i], lb[i], lc[i], ldd[i],
              lsh, lpe, s);
      ep[i*BO +: BO] = r[BO-1:0];
      es[i] = s;
    end
    bus.cfg_shift     = lsh[BS-1:0];
    bus.cfg_preadd_en = lpe;
  endtask

  task automatic stream_ops(input int j);
    for (int i = 0; i < NCH; i++) begin
      la[i]  = 1000 * j - 300 * i + 17;
      lb[i]  = 7 - j + i;
      lc[i]  = 50 * j - i;
      ldd[i] = 3 * i - j;
    end
    lsh = j % 5;
    lpe = j[0];
  endtask

  task automatic rand_ops();
    logic [26:0] t27;
    logic [15:0] t16;
    for (int i = 0; i < NCH; i++) begin
      t27 = 27'($urandom); la[i]  = $signed(t27);
      t16 = 16'($urandom); lb[i]  = $signed(t16);
      t27 = 27'($urandom); lc[i]  = $signed(t27);
      t27 = 27'($urandom); ldd[i] = $signed(t27);
      if ($urandom_range(1) == 0) begin
        la[i]  = $urandom_range(200) - 100;
        ldd[i] = $urandom_range(200) - 100;
      end
    end
    lsh = ($urandom_range(3) == 0) ?
          $urandom_range(63) : $urandom_range(32, 16);
    lpe = $urandom_range(1) == 1;
  endtask

  // One beat into an empty pipe; edges counted from the accept edge.
  task automatic single_beat(input string nm,
                             input bit has_ref,
                             input longint ref0,
                             input bit ref_sat);
    int lat;
    @(negedge clk);
    apply_ops();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({nm, " latency"}, lat, 5);
    chk({nm, " out_p"}, bus.out_p, ep);
    chk({nm, " out_sat"}, bus.out_sat, es);
    if (has_ref) begin
      chk({nm, " lane0"},
          $signed(bus.out_p[BO-1:0]), ref0);
      chk({nm, " sat0"}, bus.out_sat[0], ref_sat);
    end
    if (|es) exp_cnt++;
    @(negedge clk);
    chk({nm, " drained"}, bus.out_valid, 0);
    chk({nm, " hold"}, bus.out_p, ep);
    chk({nm, " sat_cnt"}, bus.sat_cnt, exp_cnt);
  endtask

  task automatic run_stream(input string nm,
                            input int nbeats,
                            input bit rnd,
                            input int max_cyc);
    int    sent;
    int    got;
    beat_t b;
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < max_cyc && got < nbeats;
         cyc++) begin
      @(negedge clk);
      if (rnd)
        bus.out_ready = $urandom_range(3) != 0;
      else
        bus.out_ready = !(cyc >= 7 && cyc <= 10);
      if (sent < nbeats &&
          (!rnd || $urandom_range(9) < 7)) begin
        if (rnd) rand_ops();
        else     stream_ops(sent);
        apply_ops();
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      chk({nm, " in_ready"}, bus.in_ready,
          !(bus.out_valid && !bus.out_ready));
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk({nm, " extra beat"}, 1, 0);
        end else begin
          b = q.pop_front();
          chk({nm, " out_p"}, bus.out_p, b.p);
          chk({nm, " out_sat"}, bus.out_sat, b.s);
          if (|b.s) exp_cnt++;
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back('{ep, es});
        sent++;
      end
    end
    chk({nm, " delivered"}, got, nbeats);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    int extra;

    tv[0] = '{3, 4, 10, 2, 0, 1, 30, 0};
    tv[1] = '{3, 4, 10, 2, 0, 0, 22, 0};
    tv[2] = '{0, 0, 5, 0, 1, 1, 3, 0};
    tv[3] = '{0, 0, -5, 0, 1, 1, -2, 0};
    tv[4] = '{0, 0, 7, 0, 60, 1, 0, 0};
    tv[5] = '{0, 0, 40000, 0, 0, 1, 32767, 1};
    tv[6] = '{0, 0, -40000, 0, 0, 1, -32768, 1};
    tv[7] = '{1000, -300, 0, 24, 4, 1, -19200, 0};
    tv[8] = '{-7, 3, 0, 0, 2, 1, -5, 0};
    tv[9] = '{67108863, 32767, 0, 67108863,
              30, 1, 4096, 0};

    bus.in_valid      = 1'b0;
    bus.out_ready     = 1'b0;
    bus.in_a          = '0;
    bus.in_b          = '0;
    bus.in_c          = '0;
    bus.in_d          = '0;
    bus.cfg_shift     = '0;
    bus.cfg_preadd_en = 1'b0;

    #12;
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset out_p", bus.out_p, 0);
    chk("reset out_sat", bus.out_sat, 0);
    chk("reset sat_cnt", bus.sat_cnt, 0);
    chk("reset in_ready", bus.in_ready, 1);
    @(negedge clk);
    clr = 1'b0;

    for (int j = 0; j < 10; j++) begin
      la[0]  = tv[j].a;
      lb[0]  = tv[j].b;
      lc[0]  = tv[j].c;
      ldd[0] = tv[j].d;
      for (int k = 1; k < NCH; k++) begin
        la[k]  = k * 5 - 7 + j;
        lb[k]  = k + 1;
        lc[k]  = -3 * k;
        ldd[k] = k;
      end
      lsh = tv[j].sh;
      lpe = tv[j].pe;
      single_beat($sformatf("vec%0d", j), 1'b1,
                  tv[j].exp, tv[j].esat);
    end
    chk("table sat_cnt", bus.sat_cnt, 2);

    run_stream("stall", 8, 1'b0, 100);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    chk("stall no dup", extra, 0);
    chk("stall sat_cnt", bus.sat_cnt, exp_cnt);

    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      stream_ops(j);
      lc[0] = 60000;
      apply_ops();
      bus.in_valid = 1'b1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("pre-clr out_valid", bus.out_valid, 1);
    @(posedge clk);
    #2;
    clr = 1'b1;
    #1;
    chk("clr out_valid", bus.out_valid, 0);
    chk("clr sat_cnt", bus.sat_cnt, 0);
    chk("clr out_p", bus.out_p, 0);
    exp_cnt = 0;
    q.delete();
    @(negedge clk);
    clr = 1'b0;
    stream_ops(3);
    single_beat("post-clr", 1'b0, 0, 1'b0);

    run_stream("rand", 40, 1'b1, 600);
    repeat (6) @(negedge clk);
    chk("rand sat_cnt", bus.sat_cnt, exp_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
